// File: rtl/song_pkg.sv
// ============================================================================
// Module      : song_pkg
// Description : Note bit positions and controller state type shared by the
//               song recorder and the tone-generator bank.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package song_pkg;

    localparam int NOTE_W  = 8;

    // Bit index of each note within the 8-bit key / line bus
    localparam int NOTE_C  = 0;
    localparam int NOTE_D  = 1;
    localparam int NOTE_E  = 2;
    localparam int NOTE_F  = 3;
    localparam int NOTE_G  = 4;
    localparam int NOTE_A  = 5;
    localparam int NOTE_B  = 6;
    localparam int NOTE_C2 = 7;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RECORD = 2'd1,
        PLAY   = 2'd2
    } song_state_e;

endpackage

`default_nettype wire

// File: rtl/song_recorder_tick_divider.sv
// ============================================================================
// Module      : tick_divider
// Description : Free-running clocks-per-tick counter with a synchronous clear;
//               tick is high for one clock on the last count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tick_divider #(
    parameter int TICK_DIV = 250000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST_C = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clear || (cnt_q == LAST_C)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == LAST_C);

endmodule

`default_nettype wire

// File: rtl/song_recorder.sv
// ============================================================================
// Module      : song_recorder
// Description : Records the note keys as run-length {mask, duration} events
//               and replays them on the line bus feeding the tone bank.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module song_recorder
    import song_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int ADDR_W   = 4,
    parameter int DUR_W    = 8,
    parameter int TICK_DIV = 250000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        keys,
    input  logic              rec_btn,
    input  logic              play_btn,
    output logic [7:0]        line,
    output logic              recording,
    output logic              playing,
    output logic              full,
    output logic [ADDR_W:0]   event_count
);

    typedef struct packed {
        logic [NOTE_W-1:0] mask;
        logic [DUR_W-1:0]  dur;
    } event_t;

    localparam logic [ADDR_W:0]  DEPTH_C = (ADDR_W + 1)'(DEPTH);
    localparam logic [DUR_W-1:0] DUR_MAX = {DUR_W{1'b1}};

    song_state_e       state_q, state_d;
    logic [7:0]        line_q, line_d;
    logic              recording_q, recording_d;
    logic              playing_q, playing_d;
    logic              full_q, full_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [7:0]        cur_mask_q, cur_mask_d;
    logic [DUR_W-1:0]  cur_dur_q, cur_dur_d;
    logic [DUR_W-1:0]  remaining_q, remaining_d;
    logic [ADDR_W:0]   idx_q, idx_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;

    logic [7:0]        rec_mask_t;
    logic [DUR_W-1:0]  rec_dur_t;
    logic [ADDR_W:0]   rec_count_t;

    logic              wr0_en, wr1_en;
    logic [ADDR_W-1:0] wr0_addr, wr1_addr;
    event_t            wr0_data, wr1_data;

    event_t            mem_q [DEPTH];
    event_t            rd_data;
    logic              tick;

    tick_divider #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_divider (
        .clk   (clk),
        .reset (reset),
        .clear (state_d != state_q),
        .tick  (tick)
    );

    // Read address is registered; it always points at the next event needed
    assign rd_data = mem_q[rd_addr_q];

    always_comb begin
        state_d     = state_q;
        line_d      = line_q;
        count_d     = count_q;
        cur_mask_d  = cur_mask_q;
        cur_dur_d   = cur_dur_q;
        remaining_d = remaining_q;
        idx_d       = idx_q;
        rd_addr_d   = rd_addr_q;
        rec_mask_t  = cur_mask_q;
        rec_dur_t   = cur_dur_q;
        rec_count_t = count_q;
        wr0_en      = 1'b0;
        wr0_addr    = '0;
        wr0_data    = '0;
        wr1_en      = 1'b0;
        wr1_addr    = '0;
        wr1_data    = '0;

        unique case (state_q)
            IDLE: begin
                line_d    = '0;
                idx_d     = '0;
                rd_addr_d = '0;
                if (rec_btn) begin
                    state_d    = RECORD;
                    count_d    = '0;
                    cur_mask_d = keys;
                    cur_dur_d  = '0;
                    line_d     = keys;
                end else if (play_btn && (count_q != '0)) begin
                    state_d     = PLAY;
                    line_d      = rd_data.mask;
                    remaining_d = rd_data.dur;
                    rd_addr_d   = ADDR_W'(1);
                end
            end

            RECORD: begin
                line_d = keys;
                if (tick) begin
                    if ((keys == cur_mask_q) && (cur_dur_q != DUR_MAX)) begin
                        rec_dur_t = cur_dur_q + DUR_W'(1);
                    end else begin
                        wr0_en      = 1'b1;
                        wr0_addr    = count_q[ADDR_W-1:0];
                        wr0_data    = '{mask: cur_mask_q, dur: cur_dur_q};
                        rec_count_t = count_q + (ADDR_W + 1)'(1);
                        rec_mask_t  = keys;
                        rec_dur_t   = DUR_W'(1);
                    end
                end
                cur_mask_d = rec_mask_t;
                cur_dur_d  = rec_dur_t;
                count_d    = rec_count_t;
                // The stop flush sees the post-tick event, so both writes may land together
                if (rec_count_t == DEPTH_C) begin
                    state_d = IDLE;
                    line_d  = '0;
                end else if (rec_btn) begin
                    if (rec_dur_t != '0) begin
                        wr1_en   = 1'b1;
                        wr1_addr = rec_count_t[ADDR_W-1:0];
                        wr1_data = '{mask: rec_mask_t, dur: rec_dur_t};
                        count_d  = rec_count_t + (ADDR_W + 1)'(1);
                    end
                    state_d = IDLE;
                    line_d  = '0;
                end
            end

            PLAY: begin
                if (play_btn) begin
                    state_d   = IDLE;
                    line_d    = '0;
                    rd_addr_d = '0;
                end else if (tick) begin
                    if (remaining_q > DUR_W'(1)) begin
                        remaining_d = remaining_q - DUR_W'(1);
                    end else if (remaining_q == DUR_W'(1)) begin
                        if ((idx_q + (ADDR_W + 1)'(1)) == count_q) begin
                            state_d   = IDLE;
                            line_d    = '0;
                            rd_addr_d = '0;
                        end else begin
                            idx_d       = idx_q + (ADDR_W + 1)'(1);
                            line_d      = rd_data.mask;
                            remaining_d = rd_data.dur;
                            rd_addr_d   = rd_addr_q + ADDR_W'(1);
                        end
                    end
                end
            end

            default: begin
                state_d = IDLE;
                line_d  = '0;
            end
        endcase

        recording_d = (state_d == RECORD);
        playing_d   = (state_d == PLAY);
        full_d      = (count_d == DEPTH_C);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            line_q      <= '0;
            recording_q <= 1'b0;
            playing_q   <= 1'b0;
            full_q      <= 1'b0;
            count_q     <= '0;
            cur_mask_q  <= '0;
            cur_dur_q   <= '0;
            remaining_q <= '0;
            idx_q       <= '0;
            rd_addr_q   <= '0;
        end else begin
            state_q     <= state_d;
            line_q      <= line_d;
            recording_q <= recording_d;
            playing_q   <= playing_d;
            full_q      <= full_d;
            count_q     <= count_d;
            cur_mask_q  <= cur_mask_d;
            cur_dur_q   <= cur_dur_d;
            remaining_q <= remaining_d;
            idx_q       <= idx_d;
            rd_addr_q   <= rd_addr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr0_en) begin
            mem_q[wr0_addr] <= wr0_data;
        end
        if (wr1_en) begin
            mem_q[wr1_addr] <= wr1_data;
        end
    end

    assign line        = line_q;
    assign recording   = recording_q;
    assign playing     = playing_q;
    assign full        = full_q;
    assign event_count = count_q;

endmodule

`default_nettype wire

// File: tb/tb_song_recorder.sv
// ============================================================================
// Module      : tb_song_recorder
// Description : Directed and randomized record/playback checks of
//               song_recorder against a run-length event model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_song_recorder;
    import song_pkg::*;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 2;
    localparam int DUR_W  = 4;
    localparam int TD     = 4;
    localparam int MAXD   = (1 << DUR_W) - 1;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [7:0]        keys = '0;
    logic              rec_btn = 1'b0;
    logic              play_btn = 1'b0;
    logic [7:0]        line;
    logic              recording;
    logic              playing;
    logic              full;
    logic [ADDR_W:0]   event_count;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] seq[$];
    logic [7:0] ev_mask[$];
    int         ev_dur[$];

    song_recorder #(
        .DEPTH    (DEPTH),
        .ADDR_W   (ADDR_W),
        .DUR_W    (DUR_W),
        .TICK_DIV (TD)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .keys        (keys),
        .rec_btn     (rec_btn),
        .play_btn    (play_btn),
        .line        (line),
        .recording   (recording),
        .playing     (playing),
        .full        (full),
        .event_count (event_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic add_run(input logic [7:0] m, input int n);
        repeat (n) seq.push_back(m);
    endtask

    // seq[0] is the key value at record entry, seq[j] the value seen on tick j.
    // Events are maximal runs of equal masks, chopped into MAXD-tick pieces.
    task automatic build_model();
        logic [7:0] run_mask;
        int         run_len;
        int         d;
        ev_mask.delete();
        ev_dur.delete();
        run_mask = seq[1];
        run_len  = 0;
        for (int j = 1; j <= seq.size(); j++) begin
            if (j < seq.size() && seq[j] == run_mask) begin
                run_len++;
            end else begin
                while (run_len > 0) begin
                    d = (run_len > MAXD) ? MAXD : run_len;
                    ev_mask.push_back(run_mask);
                    ev_dur.push_back(d);
                    run_len -= d;
                end
                if (j < seq.size()) begin
                    run_mask = seq[j];
                    run_len  = 1;
                end
            end
        end
        while (ev_mask.size() > DEPTH) begin
            void'(ev_mask.pop_back());
            void'(ev_dur.pop_back());
        end
    endtask

    // mode 0: stop between ticks, 1: stop on the last tick, 2: no stop (fills)
    task automatic do_record(input int mode);
        int n;
        build_model();
        n = ev_mask.size();
        @(negedge clk);
        keys    = seq[0];
        rec_btn = 1'b1;
        for (int j = 1; j < seq.size(); j++) begin
            for (int c = 0; c < TD; c++) begin
                @(negedge clk);
                rec_btn = 1'b0;
                check("rec_line", line, keys);
                check("rec_flag", recording, 1);
            end
            keys = seq[j];
        end
        if (mode == 2) begin
            @(negedge clk);
        end else begin
            if (mode == 0) begin
                @(negedge clk);
                check("rec_line", line, keys);
            end
            rec_btn = 1'b1;
            @(negedge clk);
            rec_btn = 1'b0;
        end
        check("rec_done_flag", recording, 0);
        check("rec_done_line", line, 0);
        check("rec_count", event_count, n);
        check("rec_full", full, (n == DEPTH));
    endtask

    task automatic do_play();
        @(negedge clk);
        play_btn = 1'b1;
        for (int i = 0; i < ev_mask.size(); i++) begin
            for (int c = 0; c < ev_dur[i] * TD; c++) begin
                @(negedge clk);
                play_btn = 1'b0;
                check("play_line", line, ev_mask[i]);
                check("play_flag", playing, 1);
            end
        end
        @(negedge clk);
        check("play_end_line", line, 0);
        check("play_end_flag", playing, 0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_line"}, line, 0);
        check({tag, "_rec"}, recording, 0);
        check({tag, "_play"}, playing, 0);
        check({tag, "_full"}, full, 0);
        check({tag, "_count"}, event_count, 0);
    endtask

    initial begin
        logic [7:0] c_m, e_m, g_m, ceg_m, m;
        int         tries;
        c_m   = 8'(1 << NOTE_C);
        e_m   = 8'(1 << NOTE_E);
        g_m   = 8'(1 << NOTE_G);
        ceg_m = c_m | e_m | g_m;

        repeat (2) @(negedge clk);
        check_reset_state("reset");
        reset = 1'b0;

        // Two-event recording, then exact-length playback
        seq.delete(); add_run(c_m, 4); add_run(ceg_m, 2);
        do_record(0);
        do_play();

        // Saturating duration splits one held note
        seq.delete(); add_run(g_m, 21);
        do_record(1);
        do_play();

        // Buffer fills on the fourth write
        seq.delete(); add_run(8'h01, 2); add_run(8'h02, 1); add_run(8'h04, 1);
        add_run(8'h08, 1); add_run(8'h10, 1);
        do_record(2);
        do_play();
        @(negedge clk); rec_btn = 1'b1;
        @(negedge clk); rec_btn = 1'b0;
        check("restart_rec", recording, 1);
        check("restart_count", event_count, 0);
        check("restart_full", full, 0);
        rec_btn = 1'b1;
        @(negedge clk); rec_btn = 1'b0;
        check("empty_stop_count", event_count, 0);
        play_btn = 1'b1;
        @(negedge clk); play_btn = 1'b0;
        check("empty_play_flag", playing, 0);
        check("empty_play_line", line, 0);

        // Abort mid-playback, restart from event 0, rec_btn beats play_btn
        seq.delete(); add_run(c_m, 3); add_run(e_m, 3);
        do_record(0);
        @(negedge clk); play_btn = 1'b1;
        repeat (5) begin
            @(negedge clk); play_btn = 1'b0;
        end
        check("abort_pre_line", line, c_m);
        play_btn = 1'b1;
        @(negedge clk); play_btn = 1'b0;
        check("abort_line", line, 0);
        check("abort_flag", playing, 0);
        check("abort_count", event_count, 2);
        do_play();
        rec_btn = 1'b1; play_btn = 1'b1;
        @(negedge clk); rec_btn = 1'b0; play_btn = 1'b0;
        check("both_rec", recording, 1);
        check("both_play", playing, 0);
        rec_btn = 1'b1;
        @(negedge clk); rec_btn = 1'b0;

        // Reset during playback and during recording
        seq.delete(); add_run(e_m, 3);
        do_record(0);
        @(negedge clk); play_btn = 1'b1;
        repeat (3) begin
            @(negedge clk); play_btn = 1'b0;
        end
        reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        check_reset_state("rst_play");
        keys = 8'h55; rec_btn = 1'b1;
        @(negedge clk); rec_btn = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        check_reset_state("rst_rec");

        // Randomized performances
        for (int it = 0; it < 6; it++) begin
            tries = 0;
            do begin
                seq.delete();
                m = 8'($urandom_range(0, 255));
                add_run(m, 1 + $urandom_range(1, 18));
                repeat ($urandom_range(0, 2)) begin
                    if ($urandom_range(0, 3) != 0) m = 8'($urandom_range(0, 255));
                    add_run(m, $urandom_range(1, 18));
                end
                build_model();
                tries++;
            end while (ev_mask.size() >= DEPTH && tries < 50);
            if (ev_mask.size() >= DEPTH) begin
                seq.delete(); add_run(8'hA5, 6);
            end
            do_record(int'($urandom_range(0, 1)));
            do_play();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
